// File: rtl/usart_rx_8251.sv
// 8251-compatible asynchronous receiver (8N1) with the CPU read-back path for ports 20h/21h.
// Receive holding register, RxRDY, FE and OE flags, and status byte assembly.
module usart_rx_8251 #(
  parameter int CLKS_PER_BIT = 1491,
  parameter int CNT_W        = 11
) (
  input  logic       I_CLK,
  input  logic       I_RST_N,
  input  logic       I_RXD,
  input  logic       I_RXE,
  input  logic       I_ER,
  input  logic       I_TXRDY,
  input  logic       I_TXEMPTY,
  input  logic       I_PORT20_RE,
  input  logic       I_PORT21_RE,
  output logic [7:0] O_RDATA,
  output logic       O_RXRDY
);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             tick;
  logic             load;

  logic             rxd_m, rxd_s, rxd_d;
  logic [7:0]       hold;
  logic             rxrdy, fe, oe;
  logic [1:0]       re20_sr;
  logic             re20_rise;
  logic [7:0]       status;

  // Synchronisers reset to 1 so the idle line never looks like a start edge.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= I_RXD;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign tick = (timer == '0);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = tick ? timer : timer - CNT_W'(1);
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    load        = 1'b0;
    if (!I_RXE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rxd_d && !rxd_s) begin
            state_nxt = START;
            timer_nxt = HALF_BIT;
          end
        end
        START: begin
          if (tick) begin
            if (!rxd_s) begin
              state_nxt   = DATA;
              timer_nxt   = FULL_BIT;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_nxt = {rxd_s, shift[7:1]};
            timer_nxt = FULL_BIT;
            if (bit_cnt == 3'd7) begin
              state_nxt = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Port 21h reads have no side effect, so only the data-port strobe is edge-detected.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      re20_sr <= '0;
    end else begin
      re20_sr <= {re20_sr[0], I_PORT20_RE};
    end
  end

  assign re20_rise = (re20_sr == 2'b01);

  // A load coinciding with a data-port read counts as that read being consumed: no overrun.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      hold  <= '0;
      rxrdy <= 1'b0;
      fe    <= 1'b0;
      oe    <= 1'b0;
    end else begin
      if (load) begin
        hold  <= shift;
        rxrdy <= 1'b1;
      end else if (re20_rise) begin
        rxrdy <= 1'b0;
      end
      if (I_ER) begin
        fe <= 1'b0;
        oe <= 1'b0;
      end else if (load) begin
        if (!rxd_s) fe <= 1'b1;
        if (rxrdy && !re20_rise) oe <= 1'b1;
      end
    end
  end

  assign status  = {1'b0, 1'b0, fe, oe, 1'b0, I_TXEMPTY, rxrdy, I_TXRDY};
  assign O_RDATA = I_PORT21_RE ? status : hold;
  assign O_RXRDY = rxrdy;

endmodule

// File: tb/tb_usart_rx_8251.sv
// Directed bench for usart_rx_8251 with a 16-clock bit period.
// Frames are driven on falling clock edges; outputs are sampled on falling edges.
module tb_usart_rx_8251;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rxe;
  logic       er;
  logic       txrdy;
  logic       txempty;
  logic       re20;
  logic       re21;
  logic [7:0] rdata;
  logic       rxrdy;

  int n_tests = 0;
  int n_fail  = 0;

  usart_rx_8251 #(
    .CLKS_PER_BIT(16),
    .CNT_W(5)
  ) dut (
    .I_CLK      (clk),
    .I_RST_N    (rst_n),
    .I_RXD      (rxd),
    .I_RXE      (rxe),
    .I_ER       (er),
    .I_TXRDY    (txrdy),
    .I_TXEMPTY  (txempty),
    .I_PORT20_RE(re20),
    .I_PORT21_RE(re21),
    .O_RDATA    (rdata),
    .O_RXRDY    (rxrdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // 8N1 frame; kill_rxe drops RxE at the start of data bit 3 and restores it after the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic kill_rxe);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      if (kill_rxe && i == 3) rxe = 1'b0;
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    if (kill_rxe) rxe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp);
    @(negedge clk);
    re21 = 1'b1;
    #1;
    check(tag, rdata, exp);
    re21 = 1'b0;
  endtask

  task automatic read_data(input string tag, input logic [7:0] exp);
    @(negedge clk);
    re20 = 1'b1;
    repeat (3) @(negedge clk);
    check(tag, rdata, exp);
    re20 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_er();
    @(negedge clk);
    er = 1'b1;
    repeat (2) @(negedge clk);
    er = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    rxd     = 1'b1;
    rxe     = 1'b1;
    er      = 1'b0;
    txrdy   = 1'b0;
    txempty = 1'b0;
    re20    = 1'b0;
    re21    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_rxrdy", {7'b0, rxrdy}, 8'h00);
    check("reset_data", rdata, 8'h00);
    read_status("reset_status", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Test 1: pending byte, then reset in the middle of the next frame
    send_frame(8'h5A, 1'b1, 1'b0);
    check("t1_rxrdy_before", {7'b0, rxrdy}, 8'h01);
    @(negedge clk);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_rst_rxrdy", {7'b0, rxrdy}, 8'h00);
    check("t1_rst_data", rdata, 8'h00);
    read_status("t1_rst_status", 8'h00);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Test 2: clean frame after reset, read back
    send_frame(8'h55, 1'b1, 1'b0);
    check("t2_rxrdy", {7'b0, rxrdy}, 8'h01);
    read_status("t2_status", 8'h02);
    read_data("t2_data", 8'h55);
    check("t2_rxrdy_clr", {7'b0, rxrdy}, 8'h00);
    read_status("t2_status_clr", 8'h00);

    // Test 3: overrun, then error reset
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    read_status("t3_status_oe", 8'h12);
    pulse_er();
    read_status("t3_status_er", 8'h02);
    read_data("t3_data", 8'h3C);

    // Test 4: framing error
    send_frame(8'hF0, 1'b0, 1'b0);
    read_status("t4_status_fe", 8'h22);
    pulse_er();
    read_status("t4_status_er", 8'h02);
    read_data("t4_data", 8'hF0);

    // Test 5: short glitch, then RxE dropped mid-frame; TX status passthrough
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_glitch", {7'b0, rxrdy}, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("t5_rxe_drop", {7'b0, rxrdy}, 8'h00);
    txrdy   = 1'b1;
    txempty = 1'b1;
    read_status("t5_tx_pass", 8'h05);
    txrdy   = 1'b0;
    txempty = 1'b0;

    // Test 6: data-port read rise coincides with the STOP load
    send_frame(8'h11, 1'b1, 1'b0);
    check("t6_pre_rxrdy", {7'b0, rxrdy}, 8'h01);
    fork
      send_frame(8'h81, 1'b1, 1'b0);
      begin
        @(negedge clk);
        // rise lands on the stop-sample edge, 155 posedges after the start bit is driven
        repeat (153) @(negedge clk);
        re20 = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_data", rdata, 8'h81);
        re20 = 1'b0;
      end
    join
    check("t6_rxrdy", {7'b0, rxrdy}, 8'h01);
    read_status("t6_status", 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
